led_frame_ctrl: RTL and testbench
=================================

LED_FRAME_CTRL -- requirements
Module: led_frame_ctrl

Interface
REQ-001 The block SHALL have parameter c_frame_period, default 16666, meaning clocks per frame tick.
REQ-002 The block SHALL have parameter c_frame_max, default 120, meaning frame counter modulus.
REQ-003 The block SHALL have parameter c_num_leds, default 8, meaning LED drivers in the daisy chain.
REQ-004 The block SHALL have parameter c_word_width, default 16, meaning bits per channel word.
REQ-005 The block SHALL have port i_clk, input, 1, meaning the only clock.
REQ-006 The block SHALL have port i_rst, input, 1, meaning asynchronous, active-high reset.
REQ-007 The block SHALL have port i_enable, input, 1, meaning start a refresh at each frame tick.
REQ-008 The block SHALL have port o_rd_addr, output, $clog2(c_num_leds*4), meaning pixel buffer address = led*4 + channel.
REQ-009 The block SHALL have port i_rd_data, input, c_word_width, meaning pixel buffer data, valid one clock after o_rd_addr.
REQ-010 The block SHALL have ports o_clk, o_dai and o_lat, all outputs, 1 bit each, meaning serial clock, serial data and latch to the LED chain.
REQ-011 The block SHALL have port o_frame, output, $clog2(c_frame_max), meaning the current frame number.
REQ-012 The block SHALL have port o_frame_done, output, 1, meaning a one-clock pulse after each latch.
REQ-013 The block SHALL have port o_overrun, output, 1, meaning a sticky flag set when a tick arrives while the block is busy.

Function
REQ-014 The block SHALL count r_count 0..c_frame_period-1 and wrap; the tick is the cycle r_count == c_frame_period-1.
REQ-015 At each tick, the block SHALL advance o_frame by one, wrapping c_frame_max-1 -> 0.
REQ-016 The block SHALL implement states IDLE, FETCH, LOAD, SHIFT, LATCH and DONE.
REQ-017 IDLE -> FETCH on a tick with i_enable=1; led index := c_num_leds-1 and channel := 0.
REQ-018 Channel order per LED SHALL be white(0), blue(1), green(2), red(3); LEDs are sent from c_num_leds-1 down to 0.
REQ-019 FETCH SHALL drive o_rd_addr for one clock; LOAD SHALL capture i_rd_data into the shift register on the next clock.
REQ-020 SHIFT SHALL send c_word_width bits MSB first, at 2 clocks per bit: o_dai valid with o_clk=0, then o_clk=1 with o_dai held.
REQ-021 After the last bit of a word, the block SHALL go to FETCH for the next channel/LED, or to LATCH after red of LED 0.
REQ-022 LATCH SHALL hold o_lat=1 for exactly 2 clocks with o_clk=0; then DONE pulses o_frame_done for 1 clock; then IDLE.
REQ-023 Frame length SHALL be c_num_leds*4*(2+2*c_word_width)+3 clocks (1091 at defaults), which must be less than c_frame_period.
REQ-024 A tick in any state other than IDLE SHALL set o_overrun and SHALL NOT restart the current frame.
REQ-025 Deasserting i_enable mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-026 A tick with i_enable=0 SHALL still advance o_frame and leave the state in IDLE.
REQ-027 o_clk, o_dai and o_lat SHALL be 0 in IDLE, FETCH and LOAD; o_dai SHALL be 0 in LATCH.
REQ-028 All outputs SHALL be registered; o_rd_addr holds its last value outside FETCH.

Reset
REQ-029 i_rst=1 SHALL immediately force state=IDLE, r_count=0, o_frame=0, o_clk=0, o_dai=0, o_lat=0, o_frame_done=0, o_overrun=0 and o_rd_addr=0.
REQ-030 Reset mid-SHIFT SHALL abort without issuing a latch; after release, the next tick starts a full frame from LED c_num_leds-1 channel 0.
REQ-031 After reset release, the first tick SHALL occur c_frame_period clocks later.

Verification
REQ-032 Defaults, i_enable=1, buffer word = addr*0x0101: the first tick yields o_rd_addr sequence 28,29,30,31,24,…,3; the first shifted word is 0x1C1C, MSB first.
REQ-033 Count o_clk rising edges between tick and o_lat -> exactly 512; o_lat high for 2 clocks; o_frame_done pulses 1 clock later.
REQ-034 Run 120 ticks -> o_frame goes 0..119 and then back to 0; exactly one o_frame_done per tick.
REQ-035 c_frame_period=1000 with defaults -> a tick during SHIFT sets o_overrun=1, stays set, and the in-progress frame completes unchanged.
REQ-036 Assert i_rst at clock 400 of a frame -> all outputs are 0 in the same cycle; after release, the next frame's first address is 28.
REQ-037 i_enable=0 for 3 ticks -> o_clk, o_dai and o_lat stay 0, o_frame advances by 3, and o_frame_done stays 0.

Source files
------------

// File: rtl/led_frame_ctrl.sv
// LED daisy-chain frame controller.
// A free-running counter produces a frame tick. On each enabled tick the
// block fetches four channel words per LED from a pixel buffer, from the last
// LED down to LED 0, and shifts each word out MSB first on o_clk/o_dai.
// A two-clock latch pulse and a one-clock done pulse close the frame.
module led_frame_ctrl #(
   parameter int c_frame_period = 16666,
   parameter int c_frame_max    = 120,
   parameter int c_num_leds     = 8,
   parameter int c_word_width   = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_enable,
   output logic [$clog2(c_num_leds*4)-1:0]   o_rd_addr,
   input  logic [c_word_width-1:0]           i_rd_data,
   output logic                              o_clk,
   output logic                              o_dai,
   output logic                              o_lat,
   output logic [$clog2(c_frame_max)-1:0]    o_frame,
   output logic                              o_frame_done,
   output logic                              o_overrun
);

   localparam int AW = $clog2(c_num_leds*4);
   localparam int FW = $clog2(c_frame_max);
   localparam int CW = (c_frame_period > 1) ? $clog2(c_frame_period) : 1;
   localparam int LW = (c_num_leds > 1) ? $clog2(c_num_leds) : 1;
   localparam int BW = (c_word_width > 1) ? $clog2(c_word_width) : 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      LATCH,
      DONE
   } state_t;

   state_t                  state;
   state_t                  next_state;

   logic [CW-1:0]           count;
   logic                    tick;

   logic [LW-1:0]           led;
   logic [LW-1:0]           next_led;
   logic [1:0]              ch;
   logic [1:0]              next_ch;
   logic [BW-1:0]           bit_cnt;
   logic [BW-1:0]           next_bit;
   logic                    phase;
   logic                    next_phase;
   logic                    lat_cnt;
   logic                    next_lat_cnt;
   logic [c_word_width-1:0] shreg;
   logic [c_word_width-1:0] next_shreg;
   logic [c_word_width-1:0] shifted;

   logic [AW-1:0]           next_addr;
   logic                    next_sclk;
   logic                    next_dai;
   logic                    next_lat;
   logic                    next_done;

   // Buffer address of a given LED and channel: led*4 + channel.
   function automatic logic [AW-1:0] addr_of(input logic [LW-1:0] l, input logic [1:0] c);
      addr_of = AW'(int'(l) * 4 + int'(c));
   endfunction

   assign tick = (count == CW'(c_frame_period - 1));

   // Frame period counter and frame number, advanced on every tick.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count   <= '0;
         o_frame <= '0;
      end else begin
         if (tick) begin
            count <= '0;
            if (o_frame == FW'(c_frame_max - 1)) begin
               o_frame <= '0;
            end else begin
               o_frame <= o_frame + FW'(1);
            end
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   // Sticky overrun: a tick arrived while a frame was still in progress.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overrun <= 1'b0;
      end else if (tick && (state != IDLE)) begin
         o_overrun <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, datapath updates and next values of the registered outputs.
   always_comb begin
      next_state   = state;
      next_led     = led;
      next_ch      = ch;
      next_bit     = bit_cnt;
      next_phase   = phase;
      next_lat_cnt = lat_cnt;
      next_shreg   = shreg;
      next_addr    = o_rd_addr;
      next_sclk    = 1'b0;
      next_dai     = 1'b0;
      next_lat     = 1'b0;
      next_done    = 1'b0;
      shifted      = shreg << 1;

      case (state)
         IDLE: begin
            if (tick && i_enable) begin
               next_state = FETCH;
               next_led   = LW'(c_num_leds - 1);
               next_ch    = 2'd0;
               next_addr  = addr_of(LW'(c_num_leds - 1), 2'd0);
            end
         end

         FETCH: begin
            next_state = LOAD;
         end

         LOAD: begin
            next_state = SHIFT;
            next_shreg = i_rd_data;
            next_bit   = '0;
            next_phase = 1'b0;
            next_dai   = i_rd_data[c_word_width-1];
         end

         SHIFT: begin
            if (!phase) begin
               // Second half of the bit: raise o_clk, keep data stable.
               next_phase = 1'b1;
               next_sclk  = 1'b1;
               next_dai   = shreg[c_word_width-1];
            end else begin
               next_phase = 1'b0;
               next_shreg = shifted;
               if (bit_cnt == BW'(c_word_width - 1)) begin
                  if ((led == '0) && (ch == 2'd3)) begin
                     next_state   = LATCH;
                     next_lat     = 1'b1;
                     next_lat_cnt = 1'b0;
                  end else begin
                     next_state = FETCH;
                     if (ch == 2'd3) begin
                        next_ch  = 2'd0;
                        next_led = led - LW'(1);
                     end else begin
                        next_ch = ch + 2'd1;
                     end
                     next_addr = addr_of(next_led, next_ch);
                  end
               end else begin
                  next_bit = bit_cnt + BW'(1);
                  next_dai = shifted[c_word_width-1];
               end
            end
         end

         LATCH: begin
            if (!lat_cnt) begin
               next_lat     = 1'b1;
               next_lat_cnt = 1'b1;
            end else begin
               next_state = DONE;
               next_done  = 1'b1;
            end
         end

         DONE: begin
            next_state = IDLE;
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         led          <= '0;
         ch           <= '0;
         bit_cnt      <= '0;
         phase        <= 1'b0;
         lat_cnt      <= 1'b0;
         shreg        <= '0;
         o_rd_addr    <= '0;
         o_clk        <= 1'b0;
         o_dai        <= 1'b0;
         o_lat        <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         led          <= next_led;
         ch           <= next_ch;
         bit_cnt      <= next_bit;
         phase        <= next_phase;
         lat_cnt      <= next_lat_cnt;
         shreg        <= next_shreg;
         o_rd_addr    <= next_addr;
         o_clk        <= next_sclk;
         o_dai        <= next_dai;
         o_lat        <= next_lat;
         o_frame_done <= next_done;
      end
   end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Self-checking bench for led_frame_ctrl: table vectors on the first frame,
// a per-cycle reference model under random buffer data and random enable,
// plus sequences for enable-off, mid-frame reset and overrun.
module tb_led_frame_ctrl;

   localparam int P   = 1200;
   localparam int M   = 8;
   localparam int N   = 8;
   localparam int W   = 16;
   localparam int AW  = 5;
   localparam int FW  = 3;
   localparam int WL  = 2 + 2 * W;
   localparam int NW  = N * 4;
   localparam int L   = NW * WL + 3;
   localparam int P2  = 1000;
   localparam int TRN = 2400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          enable;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          sclk, dai, lat, done, ovr;
   logic [FW-1:0] frame;

   logic          rst2;
   logic          en2;
   logic [AW-1:0] rd_addr2;
   logic [W-1:0]  rd_data2;
   logic          sclk2, dai2, lat2, done2, ovr2;
   logic [6:0]    frame2;

   logic [W-1:0]  mem [NW];

   int vectors     = 0;
   int miscompares = 0;

   led_frame_ctrl #(
      .c_frame_period(P),
      .c_frame_max(M),
      .c_num_leds(N),
      .c_word_width(W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable),
      .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_clk(sclk), .o_dai(dai), .o_lat(lat),
      .o_frame(frame), .o_frame_done(done), .o_overrun(ovr)
   );

   led_frame_ctrl #(
      .c_frame_period(P2)
   ) dut_ovr (
      .i_clk(clk), .i_rst(rst2), .i_enable(en2),
      .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
      .o_clk(sclk2), .o_dai(dai2), .o_lat(lat2),
      .o_frame(frame2), .o_frame_done(done2), .o_overrun(ovr2)
   );

   // Pixel buffer with one clock of read latency.
   always @(posedge clk) begin
      rd_data  <= mem[rd_addr];
      rd_data2 <= mem[rd_addr2];
   end

   // Cycle index since reset release (0 = first cycle after release).
   int n = 0;
   always @(posedge clk) n <= rst ? 0 : n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs k cycles after a starting tick, from the frame layout:
   // each word takes WL cycles (fetch, load, 2 per bit), then latch x2, done.
   function automatic void model(input int k, output logic ec, output logic ed,
                                 output logic el, output logic edn,
                                 output logic av, output logic [AW-1:0] ea);
      int w, pos, ledi, chi;
      logic [W-1:0] word;
      ec = 1'b0; ed = 1'b0; el = 1'b0; edn = 1'b0; av = 1'b0; ea = '0;
      if (k >= 1 && k <= NW * WL) begin
         w    = (k - 1) / WL;
         pos  = (k - 1) % WL;
         ledi = N - 1 - w / 4;
         chi  = w % 4;
         ea   = AW'(ledi * 4 + chi);
         av   = 1'b1;
         if (pos >= 2) begin
            word = mem[ledi * 4 + chi];
            ed   = word[W - 1 - (pos - 2) / 2];
            ec   = ((pos - 2) % 2) == 1;
         end
      end else if (k == NW * WL + 1 || k == NW * WL + 2) begin
         el = 1'b1;
      end else if (k == NW * WL + 3) begin
         edn = 1'b1;
      end
   endfunction

   int   start   = -1;
   logic exp_ovr = 1'b0;
   bit   trace_on = 1'b1;
   logic          tr_clk  [TRN];
   logic          tr_dai  [TRN];
   logic          tr_lat  [TRN];
   logic          tr_done [TRN];
   logic [AW-1:0] tr_addr [TRN];

   // Per-cycle reference comparison for the main instance.
   always @(negedge clk) begin
      logic ec, ed, el, edn, av;
      logic [AW-1:0] ea;
      int k;
      if (rst) begin
         start   = -1;
         exp_ovr = 1'b0;
      end else begin
         k = (start >= 0) ? n - start : -1;
         model(k, ec, ed, el, edn, av, ea);
         check("o_clk", sclk, ec);
         check("o_dai", dai, ed);
         check("o_lat", lat, el);
         check("o_frame_done", done, edn);
         check("o_frame", frame, (n / P) % M);
         check("o_overrun", ovr, exp_ovr);
         if (av) check("o_rd_addr", rd_addr, ea);
         if (trace_on && n < TRN) begin
            tr_clk[n]  = sclk;
            tr_dai[n]  = dai;
            tr_lat[n]  = lat;
            tr_done[n] = done;
            tr_addr[n] = rd_addr;
         end
         if (n % P == P - 1) begin
            if (start >= 0 && n - start <= L) exp_ovr = 1'b1;
            else if (enable) start = n;
         end
      end
   end

   typedef struct {
      int            k;
      logic [AW-1:0] addr;
      logic          c, d, l, dn;
   } vec_t;

   vec_t tbl[22];

   // Main sequence.
   initial begin : main_seq
      int rises, lat_start, lat_cnt, done_cnt, bad, f0, lat_seen;
      rst    = 1'b1;
      enable = 1'b1;
      for (int a = 0; a < NW; a++) mem[a] = W'(a * 16'h0101);

      tbl[0]  = '{1,    5'd28, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2,    5'd28, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{3,    5'd28, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4,    5'd28, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{9,    5'd28, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{10,   5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{13,   5'd28, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{15,   5'd28, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{25,   5'd28, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{34,   5'd28, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{35,   5'd29, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{68,   5'd29, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{69,   5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{103,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{137,  5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1055, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1056, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1088, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
      tbl[18] = '{1089, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[19] = '{1090, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[20] = '{1091, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[21] = '{1092, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_addr", rd_addr, 0);
      check("rst_o_clk", sclk, 0);
      check("rst_o_dai", dai, 0);
      check("rst_o_lat", lat, 0);
      check("rst_o_frame", frame, 0);
      check("rst_o_frame_done", done, 0);
      check("rst_o_overrun", ovr, 0);
      rst = 1'b0;

      // First frame with deterministic buffer contents.
      repeat (TRN) step();
      trace_on = 1'b0;
      foreach (tbl[i]) begin
         check("tbl_rd_addr", tr_addr[P - 1 + tbl[i].k], tbl[i].addr);
         check("tbl_o_clk",   tr_clk[P - 1 + tbl[i].k],  tbl[i].c);
         check("tbl_o_dai",   tr_dai[P - 1 + tbl[i].k],  tbl[i].d);
         check("tbl_o_lat",   tr_lat[P - 1 + tbl[i].k],  tbl[i].l);
         check("tbl_o_frame_done", tr_done[P - 1 + tbl[i].k], tbl[i].dn);
      end

      rises = 0; lat_start = -1; lat_cnt = 0; done_cnt = 0;
      for (int c = P; c < TRN - 1; c++) begin
         if (lat_start < 0 && tr_clk[c] && !tr_clk[c-1]) rises++;
         if (tr_lat[c] && lat_start < 0) lat_start = c;
         if (tr_lat[c]) lat_cnt++;
         if (tr_done[c]) done_cnt++;
      end
      check("clk_rises_to_latch", rises, 512);
      check("latch_start", lat_start, P - 1 + NW * WL + 1);
      check("latch_width", lat_cnt, 2);
      check("done_count", done_cnt, 1);
      check("done_after_latch", tr_done[lat_start + 2], 1);

      // Random buffer data and random enable (changed mid-frame).
      repeat (13150) begin
         step();
         if (n % P == 600) enable = ($urandom_range(0, 3) != 0);
         if (n % P == 1150) for (int a = 0; a < NW; a++) mem[a] = W'($urandom);
      end

      // Three ticks with enable low.
      enable = 1'b0;
      f0 = int'(frame);
      bad = 0; done_cnt = 0;
      repeat (3 * P) begin
         step();
         if (sclk || dai || lat) bad++;
         if (done) done_cnt++;
      end
      check("disabled_frame_adv", frame, (f0 + 3) % M);
      check("disabled_serial_idle", bad, 0);
      check("disabled_no_done", done_cnt, 0);

      // Reset 400 clocks into a frame.
      enable = 1'b1;
      for (int i = 0; i < 2 * P && (n % P) != 399; i++) step();
      check("pre_reset_busy_lat", lat, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_rd_addr", rd_addr, 0);
      check("mid_rst_o_clk", sclk, 0);
      check("mid_rst_o_dai", dai, 0);
      check("mid_rst_o_lat", lat, 0);
      check("mid_rst_o_frame", frame, 0);
      check("mid_rst_o_frame_done", done, 0);
      check("mid_rst_o_overrun", ovr, 0);
      repeat (2) step();
      rst = 1'b0;
      lat_seen = 0;
      repeat (P) begin
         step();
         if (lat || done) lat_seen++;
      end
      check("post_rst_first_addr", rd_addr, 28);
      check("post_rst_no_latch", lat_seen, 0);
      check("post_rst_frame", frame, 1);
      repeat (P) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Overrun instance: the second tick lands in SHIFT of the first frame.
   initial begin : ovr_seq
      int   rises, lat_at;
      logic prev;
      rst2 = 1'b1;
      en2  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst2 = 1'b0;
      rises = 0; lat_at = -1; prev = 1'b0;
      for (int c = 0; c <= 3000; c++) begin
         @(negedge clk);
         if (c >= P2 && lat_at < 0) begin
            if (sclk2 && !prev) rises++;
            if (lat2) lat_at = c;
         end
         prev = sclk2;
         if (c == 1998) check("ovr_before_tick", ovr2, 0);
         if (c == 2000) check("ovr_set", ovr2, 1);
         if (c == 2000) check("ovr_frame_num", frame2, 2);
         if (c == 2089) check("ovr_done_early", done2, 0);
         if (c == 2090) check("ovr_done", done2, 1);
         if (c == 3000) check("ovr_sticky", ovr2, 1);
      end
      check("ovr_clk_rises", rises, 512);
      check("ovr_latch_at", lat_at, P2 - 1 + NW * WL + 1);
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
      $fatal(1);
   end

endmodule
